// File: rtl/seg_scan_if.sv
// Bundle between a display scan controller and whatever owns the digit data.
// The master side writes digits and sets display modes. The slave side drives the decoder and the anodes.
interface seg_scan_if #(
  parameter int NDIG = 8
) ();
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic            en;
  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [3:0]      wr_data;
  logic            wr_blank;
  logic            lzs;
  logic [NDIG-1:0] blink_mask;
  logic [3:0]      seg_code;
  logic [NDIG-1:0] an_n;
  logic            frame_done;

  modport master (
    output en, wr_en, wr_idx, wr_data, wr_blank, lzs, blink_mask,
    input  seg_code, an_n, frame_done
  );

  modport slave (
    input  en, wr_en, wr_idx, wr_data, wr_blank, lzs, blink_mask,
    output seg_code, an_n, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display. It supports leading-zero suppression, per-digit blank and blink, and a guard gap between digits.
// Outputs are registered every cycle from the current state, so they trail the FSM state by one clock.
module seg_scan_ctrl #(
  parameter int NDIG      = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int GAP_CYC   = 2,
  parameter int BLINK_DIV = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CMAX = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IW-1:0] PTR_LAST   = IW'(NDIG - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic          HAS_GAP    = (GAP_CYC > 0);

  typedef enum logic [1:0] {OFF, DRIVE, GAP} state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [BW-1:0]   frm_cnt_q;
  logic            phase_q;
  logic [3:0]      code_q [NDIG];
  logic [NDIG-1:0] blank_q;
  logic [3:0]      seg_code_q;
  logic [NDIG-1:0] an_n_q;
  logic            frame_done_q;

  logic [NDIG:0]   allz_d;
  logic [NDIG-1:0] hide_d;
  logic            slot_end_d;
  logic            gap_end_d;
  logic            frame_end_d;
  logic [IW-1:0]   ptr_next_d;
  logic            wr_ok_d;

  // allz_d[i]: every code from digit i upward is zero (leading-zero run)
  always_comb begin
    allz_d       = '0;
    allz_d[NDIG] = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      allz_d[i] = allz_d[i+1] && (code_q[i] == 4'h0);
    end
    hide_d = '0;
    for (int i = 0; i < NDIG; i++) begin
      hide_d[i] = blank_q[i] || (bus.blink_mask[i] && phase_q) ||
                  (bus.lzs && (i != 0) && allz_d[i]);
    end
  end

  always_comb begin
    slot_end_d  = (state_q == DRIVE) && (cnt_q == SCAN_LAST);
    gap_end_d   = (state_q == GAP) && (cnt_q == GAP_LAST);
    frame_end_d = bus.en && (ptr_q == PTR_LAST) && (HAS_GAP ? gap_end_d : slot_end_d);
    ptr_next_d  = (ptr_q == PTR_LAST) ? '0 : ptr_q + IW'(1);
    wr_ok_d     = bus.wr_en && (32'(bus.wr_idx) < 32'(NDIG));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q <= '0;
      for (int i = 0; i < NDIG; i++) code_q[i] <= 4'h0;
    end else if (wr_ok_d) begin
      code_q[bus.wr_idx]  <= bus.wr_data;
      blank_q[bus.wr_idx] <= bus.wr_blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OFF;
      ptr_q        <= '0;
      cnt_q        <= '0;
      frm_cnt_q    <= '0;
      phase_q      <= 1'b0;
      seg_code_q   <= 4'h0;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end_d;
      if (!bus.en) begin
        state_q <= OFF;
        ptr_q   <= '0;
        cnt_q   <= '0;
        an_n_q  <= '1;
      end else begin
        an_n_q <= '1;
        if (state_q == DRIVE) begin
          seg_code_q <= code_q[ptr_q];
          if (!hide_d[ptr_q]) an_n_q <= ~(NDIG'(1) << ptr_q);
        end
        case (state_q)
          OFF: begin
            state_q <= DRIVE;
            ptr_q   <= '0;
            cnt_q   <= '0;
          end
          DRIVE: begin
            if (slot_end_d) begin
              cnt_q <= '0;
              if (HAS_GAP) state_q <= GAP;
              else         ptr_q   <= ptr_next_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          GAP: begin
            if (gap_end_d) begin
              cnt_q   <= '0;
              state_q <= DRIVE;
              ptr_q   <= ptr_next_d;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= OFF;
        endcase
      end
      // Blink phase flips once every BLINK_DIV completed frames
      if (frame_end_d) begin
        if (frm_cnt_q == BLINK_LAST) begin
          frm_cnt_q <= '0;
          phase_q   <= ~phase_q;
        end else begin
          frm_cnt_q <= frm_cnt_q + BW'(1);
        end
      end
    end
  end

  assign bus.seg_code   = seg_code_q;
  assign bus.an_n       = an_n_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl. It uses a 4-digit instance with a 1-cycle gap and a 3-digit instance without a gap.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  seg_scan_if #(.NDIG(4)) bus ();
  seg_scan_if #(.NDIG(3)) bus3 ();

  seg_scan_ctrl #(.NDIG(4), .SCAN_DIV(4), .GAP_CYC(1), .BLINK_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  seg_scan_ctrl #(.NDIG(3), .SCAN_DIV(1), .GAP_CYC(0), .BLINK_DIV(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       wr;
    logic [1:0] idx;
    logic [3:0] data;
    logic [3:0] exp_an;
    logic [3:0] exp_seg;
    logic       exp_fd;
  } vec_t;
  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.en = 0; bus.wr_en = 0; bus.wr_idx = 0; bus.wr_data = 0; bus.wr_blank = 0;
    bus.lzs = 0; bus.blink_mask = 0;
    bus3.en = 0; bus3.wr_en = 0; bus3.wr_idx = 0; bus3.wr_data = 0; bus3.wr_blank = 0;
    bus3.lzs = 0; bus3.blink_mask = 0;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic wr(input logic [1:0] idx, input logic [3:0] data, input logic blank);
    bus.wr_en = 1; bus.wr_idx = idx; bus.wr_data = data; bus.wr_blank = blank;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic load1234();
    wr(0, 4'd1, 0); wr(1, 4'd2, 0); wr(2, 4'd3, 0); wr(3, 4'd4, 0);
  endtask

  task automatic start();
    bus.en = 1;
    tick();
  endtask

  // Called with the FSM at the start of digit 0 DRIVE; returns at the start of the next frame
  task automatic run_frame(input string nm, input logic [3:0] lit,
                           input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3);
    logic [3:0] segs [4];
    logic [3:0] e;
    segs = '{s0, s1, s2, s3};
    for (int d = 0; d < 4; d++) begin
      e = lit[d] ? ~(4'b0001 << d) : 4'hF;
      for (int k = 0; k < 4; k++) begin
        tick();
        chk($sformatf("%s an_n d%0d c%0d", nm, d, k), 32'(bus.an_n), 32'(e));
        chk($sformatf("%s seg d%0d c%0d", nm, d, k), 32'(bus.seg_code), 32'(segs[d]));
      end
      tick();
      chk($sformatf("%s gap an_n d%0d", nm, d), 32'(bus.an_n), 32'hF);
      chk($sformatf("%s frame_done d%0d", nm, d), 32'(bus.frame_done), (d == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int fd_seen;

    // Test 1: basic scan, driven from the vector table
    do_reset();
    chk("reset an_n", 32'(bus.an_n), 32'hF);
    chk("reset seg", 32'(bus.seg_code), 32'h0);
    chk("reset frame_done", 32'(bus.frame_done), 32'h0);
    tbl.push_back('{0, 1, 2'd0, 4'd1, 4'hF, 4'h0, 0});
    tbl.push_back('{0, 1, 2'd1, 4'd2, 4'hF, 4'h0, 0});
    tbl.push_back('{0, 1, 2'd2, 4'd3, 4'hF, 4'h0, 0});
    tbl.push_back('{0, 1, 2'd3, 4'd4, 4'hF, 4'h0, 0});
    tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hF, 4'h0, 0});
    for (int k = 0; k < 4; k++) tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hE, 4'h1, 0});
    tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hF, 4'h1, 0});
    for (int k = 0; k < 4; k++) tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hD, 4'h2, 0});
    tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hF, 4'h2, 0});
    for (int k = 0; k < 4; k++) tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hB, 4'h3, 0});
    tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hF, 4'h3, 0});
    for (int k = 0; k < 4; k++) tbl.push_back('{1, 0, 2'd0, 4'd0, 4'h7, 4'h4, 0});
    tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hF, 4'h4, 1});
    tbl.push_back('{1, 0, 2'd0, 4'd0, 4'hE, 4'h1, 0});
    foreach (tbl[i]) begin
      bus.en = tbl[i].en; bus.wr_en = tbl[i].wr; bus.wr_idx = tbl[i].idx;
      bus.wr_data = tbl[i].data; bus.wr_blank = 0;
      tick();
      chk($sformatf("t1 row%0d an_n", i), 32'(bus.an_n), 32'(tbl[i].exp_an));
      chk($sformatf("t1 row%0d seg", i), 32'(bus.seg_code), 32'(tbl[i].exp_seg));
      chk($sformatf("t1 row%0d frame_done", i), 32'(bus.frame_done), 32'(tbl[i].exp_fd));
    end
    bus.wr_en = 0;
    fd_seen = 0;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (bus.frame_done) fd_seen++;
    end
    tick();
    chk("t1 no early frame_done", 32'(fd_seen), 32'd0);
    chk("t1 frame period 20", 32'(bus.frame_done), 32'd1);

    // Test 2: leading-zero suppression
    do_reset();
    wr(0, 4'd0, 0); wr(1, 4'd5, 0); wr(2, 4'd0, 0); wr(3, 4'd0, 0);
    bus.lzs = 1;
    start();
    run_frame("t2 lzs1", 4'b0011, 4'd0, 4'd5, 4'd0, 4'd0);
    bus.lzs = 0;
    run_frame("t2 lzs0", 4'b1111, 4'd0, 4'd5, 4'd0, 4'd0);

    // Test 3: blink on digit 0, blank flag on digit 2
    do_reset();
    wr(0, 4'd1, 0); wr(1, 4'd2, 0); wr(2, 4'd3, 1); wr(3, 4'd4, 0);
    bus.blink_mask = 4'b0001;
    start();
    run_frame("t3 f0", 4'b1011, 4'd1, 4'd2, 4'd3, 4'd4);
    run_frame("t3 f1", 4'b1011, 4'd1, 4'd2, 4'd3, 4'd4);
    run_frame("t3 f2", 4'b1010, 4'd1, 4'd2, 4'd3, 4'd4);
    run_frame("t3 f3", 4'b1010, 4'd1, 4'd2, 4'd3, 4'd4);
    run_frame("t3 f4", 4'b1011, 4'd1, 4'd2, 4'd3, 4'd4);
    run_frame("t3 f5", 4'b1011, 4'd1, 4'd2, 4'd3, 4'd4);

    // Test 4: rewrite the digit being driven
    do_reset();
    load1234();
    start();
    for (int k = 0; k < 5; k++) tick();
    chk("t4 gap0 an_n", 32'(bus.an_n), 32'hF);
    tick();
    chk("t4 c0 an_n", 32'(bus.an_n), 32'hD);
    chk("t4 c0 seg", 32'(bus.seg_code), 32'h2);
    bus.wr_en = 1; bus.wr_idx = 1; bus.wr_data = 4'd9; bus.wr_blank = 0;
    tick();
    bus.wr_en = 0;
    chk("t4 c1 an_n", 32'(bus.an_n), 32'hD);
    chk("t4 c1 seg", 32'(bus.seg_code), 32'h2);
    tick();
    chk("t4 c2 an_n", 32'(bus.an_n), 32'hD);
    chk("t4 c2 seg", 32'(bus.seg_code), 32'h9);
    tick();
    chk("t4 c3 an_n", 32'(bus.an_n), 32'hD);
    chk("t4 c3 seg", 32'(bus.seg_code), 32'h9);
    tick();
    chk("t4 gap1 an_n", 32'(bus.an_n), 32'hF);

    // Test 5: disable mid-scan, then restart
    do_reset();
    load1234();
    start();
    for (int k = 0; k < 11; k++) tick();
    chk("t5 d2 an_n", 32'(bus.an_n), 32'hB);
    chk("t5 d2 seg", 32'(bus.seg_code), 32'h3);
    bus.en = 0;
    tick();
    chk("t5 off an_n", 32'(bus.an_n), 32'hF);
    chk("t5 off seg hold", 32'(bus.seg_code), 32'h3);
    tick();
    chk("t5 off2 an_n", 32'(bus.an_n), 32'hF);
    bus.en = 1;
    tick();
    chk("t5 restart e0 an_n", 32'(bus.an_n), 32'hF);
    tick();
    chk("t5 restart an_n", 32'(bus.an_n), 32'hE);
    chk("t5 restart seg", 32'(bus.seg_code), 32'h1);

    // Test 6: short asynchronous reset mid-scan
    do_reset();
    load1234();
    start();
    for (int k = 0; k < 7; k++) tick();
    chk("t6 pre an_n", 32'(bus.an_n), 32'hD);
    #2 rst_n = 0;
    #1;
    chk("t6 async an_n", 32'(bus.an_n), 32'hF);
    chk("t6 async seg", 32'(bus.seg_code), 32'h0);
    chk("t6 async frame_done", 32'(bus.frame_done), 32'h0);
    #2 rst_n = 1;
    tick();
    chk("t6 e0 an_n", 32'(bus.an_n), 32'hF);
    run_frame("t6 cleared", 4'b1111, 4'd0, 4'd0, 4'd0, 4'd0);

    // Test 7: 3-digit instance, no gap, out-of-range write index
    do_reset();
    bus3.wr_en = 1;
    for (int i = 0; i < 3; i++) begin
      bus3.wr_idx = 2'(i); bus3.wr_data = 4'(i + 1);
      tick();
    end
    bus3.wr_idx = 2'd3; bus3.wr_data = 4'd7;
    tick();
    bus3.wr_en = 0;
    bus3.en = 1;
    tick();
    chk("t7 e0 an_n", 32'(bus3.an_n), 32'h7);
    for (int r = 0; r < 2; r++) begin
      tick();
      chk($sformatf("t7 r%0d d0 an_n", r), 32'(bus3.an_n), 32'h6);
      chk($sformatf("t7 r%0d d0 seg", r), 32'(bus3.seg_code), 32'h1);
      tick();
      chk($sformatf("t7 r%0d d1 an_n", r), 32'(bus3.an_n), 32'h5);
      chk($sformatf("t7 r%0d d1 seg", r), 32'(bus3.seg_code), 32'h2);
      chk($sformatf("t7 r%0d d1 frame_done", r), 32'(bus3.frame_done), 32'h0);
      tick();
      chk($sformatf("t7 r%0d d2 an_n", r), 32'(bus3.an_n), 32'h3);
      chk($sformatf("t7 r%0d d2 seg", r), 32'(bus3.seg_code), 32'h3);
      chk($sformatf("t7 r%0d frame_done", r), 32'(bus3.frame_done), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
